mp_add_sequencer: RTL and testbench
===================================

// Module: mp_add_sequencer
// PURPOSE
//   Word-serial multiprecision add/subtract controller for the shared WIDTH-bit Knowles prefix adder.
//   Accepts a command, then streams WORDS operand word pairs, LS word first, through the external
//   combinational adder and chains the carry between words. Emits the result words with final
//   carry-out and signed-overflow flags.
//   Sits between the ALU command front end and the knowles32 adder instance.
// PARAMETERS
//   WIDTH  32  adder/word width in bits; must match the attached adder core
//   WORDS  4   words per operand (>=1); counter width = max(1,$clog2(WORDS))
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   cmd_valid   in   1      command request
//   cmd_ready   out  1      high only in IDLE
//   cmd_sub     in   1      1 = A-B (invert B, cin=1); 0 = A+B (cin=0)
//   abort       in   1      synchronous cancel; highest priority after reset
//   in_valid    in   1      operand word pair valid
//   in_ready    out  1      operand word pair accepted when in_valid&in_ready
//   in_a        in   WIDTH  operand A word
//   in_b        in   WIDTH  operand B word
//   out_valid   out  1      result word valid (registered)
//   out_ready   in   1      downstream accepts result word
//   out_sum     out  WIDTH  result word
//   out_last    out  1      marks the MS (final) result word
//   out_cout    out  1      final carry-out (add) / NOT-borrow (sub); meaningful only with out_last
//   out_ovf     out  1      signed overflow of full-width result; meaningful only with out_last
//   adder_a     out  WIDTH  to adder core A
//   adder_b     out  WIDTH  to adder core B (in_b or ~in_b)
//   adder_cin   out  1      to adder core carry-in
//   adder_sum   in   WIDTH  from adder core, same-cycle combinational
//   adder_cout  in   1      from adder core, same-cycle combinational
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, cmd_ready=1, in_ready=0.
//     out_valid/out_last/out_cout/out_ovf=0, out_sum=0. Internal carry=0, sub=0, word count=0.
//   States:
//   - IDLE: cmd_ready=1.
//     On cmd_valid: latch sub=cmd_sub, carry=cmd_sub, count=0 -> RUN.
//   - RUN: in_ready = !out_valid | out_ready (1-entry output register).
//     On each input handshake:
//       out_sum <= adder_sum; out_valid <= 1; out_last <= (count==WORDS-1).
//       carry <= adder_cout; count++.
//     On the last word: out_cout <= adder_cout.
//       out_ovf <= (in_a[MSB]==adder_b[MSB]) & (adder_sum[MSB]!=in_a[MSB]).
//       Then -> DRAIN.
//   - DRAIN: in_ready=0. When the last word's out handshake occurs -> IDLE.
//   Output register: out_valid clears on out handshake unless a new word loads in the same cycle.
//     out_* stay stable while out_valid & !out_ready.
//   Adder drive is combinational:
//     In RUN: adder_a=in_a, adder_b = sub ? ~in_b : in_b, adder_cin=carry.
//     Otherwise all zero.
//     Values are valid regardless of in_valid; only handshaked words update state.
//   Latency: result word 1 cycle after its input handshake.
//     Throughput: 1 word/cycle with out_ready held high.
//     Full op: WORDS+1 cycles from cmd handshake to IDLE.
//   WORDS=1: first word is last; RUN -> DRAIN after one handshake.
//   cmd_valid outside IDLE is ignored (not queued).
//     A new command is accepted no earlier than the cycle after return to IDLE.
//   abort=1 (any state): next edge -> IDLE, out_valid=0, out_last=0, carry/count cleared.
//     Input handshake in that cycle is discarded.
//   Reset mid-operation: immediate reset values; partial result lost; no output completes.
// TESTING
//   1 add, WORDS=4: A={FFFFFFFF x4}, B={00000001,0,0,0} (LS first)
//     -> sums 0,0,0,0; last: cout=1, ovf=0.
//   2 sub: A=0, B=1 -> sums FFFFFFFF x4; cout=0 (borrow); ovf=0; adder_cin=1 on first word.
//   3 add: A MS=7FFFFFFF, lower 0; B MS=00000001, lower 0
//     -> MS sum 80000000, ovf=1, cout=0.
//   4 out_ready=0 for 3 cycles after word 0 -> in_ready=0, out_sum held.
//     Carry preserved; resume gives the same results as test 1.
//   5 abort after 2 words of an add -> next cycle IDLE, out_valid=0, cmd_ready=1.
//     A following sub computes correctly from cin=1.
//   6 rst_n low mid-RUN (async, between edges) -> all outputs at reset values immediately.
//     Then a fresh command completes normally.

Source files
------------

// File: rtl/mp_add_sequencer.sv
// Word-serial multiprecision add/subtract sequencer driving an external WIDTH-bit adder.
// The carry is chained between words, and the final word reports carry-out and signed overflow.
module mp_add_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned WORDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sub,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_cin,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic             adder_cout
);

    localparam int unsigned CW  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              sub_q, sub_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_sum_q, out_sum_d;
    logic              out_last_q, out_last_d;
    logic              out_cout_q, out_cout_d;
    logic              out_ovf_q, out_ovf_d;
    logic              in_fire;
    logic              last_word;

    // State register and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Next-state, handshakes and adder drive
    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        count_d     = count_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        adder_a     = '0;
        adder_b     = '0;
        adder_cin   = 1'b0;

        if (state_q == S_RUN) begin
            adder_a   = in_a;
            adder_b   = sub_q ? ~in_b : in_b;
            adder_cin = carry_q;
            in_ready  = ~out_valid_q | out_ready;
        end
        in_fire   = in_valid & in_ready;
        last_word = (count_q == CW'(WORDS - 1));

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    sub_d   = cmd_sub;
                    carry_d = cmd_sub;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (in_fire) begin
                    out_sum_d   = adder_sum;
                    out_valid_d = 1'b1;
                    out_last_d  = last_word;
                    carry_d     = adder_cout;
                    if (last_word) begin
                        count_d    = '0;
                        out_cout_d = adder_cout;
                        out_ovf_d  = (in_a[MSB] == adder_b[MSB]) & (adder_sum[MSB] != in_a[MSB]);
                        state_d    = S_DRAIN;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a same-cycle input handshake
        if (abort) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            carry_d     = 1'b0;
            count_d     = '0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed self-checking bench for mp_add_sequencer (WIDTH=32, WORDS=4) with a behavioural adder.
module tb_mp_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_sub, abort;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready, out_last, out_cout, out_ovf;
    logic [31:0] out_sum;
    logic [31:0] adder_a, adder_b, adder_sum;
    logic        adder_cin, adder_cout;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    // Stand-in for the external combinational adder core
    assign {adder_cout, adder_sum} = 33'(adder_a) + 33'(adder_b) + 33'(adder_cin);

    mp_add_sequencer #(.WIDTH(32), .WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sub(cmd_sub), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_last(out_last), .out_cout(out_cout), .out_ovf(out_ovf),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_sum(adder_sum), .adder_cout(adder_cout)
    );

    // Runs one full operation with out_ready held high; starts and ends on a negedge.
    task automatic run_op(input logic sub, input logic [3:0][31:0] a, input logic [3:0][31:0] b,
                          output logic [3:0][31:0] sums, output logic [3:0] lasts,
                          output logic cout, output logic ovf, output logic first_cin,
                          output logic proto_ok);
        proto_ok  = 1'b1;
        first_cin = 1'b0;
        cmd_valid = 1'b1;
        cmd_sub   = sub;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (cmd_ready !== 1'b0) proto_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = a[i];
            in_b     = b[i];
            #1;
            if (i == 0) first_cin = adder_cin;
            if (in_ready !== 1'b1) proto_ok = 1'b0;
            @(negedge clk);
            sums[i]  = out_sum;
            lasts[i] = out_last;
            if (out_valid !== 1'b1) proto_ok = 1'b0;
        end
        in_valid = 1'b0;
        cout     = out_cout;
        ovf      = out_ovf;
        @(negedge clk);
        if (cmd_ready !== 1'b1 || out_valid !== 1'b0) proto_ok = 1'b0;
    endtask

    task automatic test_reset();
        cmp_cnt++;
        if ({cmd_ready, in_ready, out_valid, out_last, out_cout, out_ovf} !== 6'b100000) begin
            err_cnt++;
            $display("FAIL reset_ctl: got %b want 100000",
                     {cmd_ready, in_ready, out_valid, out_last, out_cout, out_ovf});
        end
        cmp_cnt++;
        if (out_sum !== 32'h0 || adder_a !== 32'h0 || adder_b !== 32'h0 || adder_cin !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_data: sum=%h a=%h b=%h cin=%b want zeros", out_sum, adder_a, adder_b, adder_cin);
        end
    endtask

    task automatic test_add_carry();
        logic [3:0][31:0] s; logic [3:0] l; logic co, ov, ci, ok;
        run_op(1'b0, {4{32'hFFFF_FFFF}}, {32'h0, 32'h0, 32'h0, 32'h1}, s, l, co, ov, ci, ok);
        cmp_cnt++;
        if (s !== 128'h0) begin err_cnt++; $display("FAIL add_sums: got %h want 0", s); end
        cmp_cnt++;
        if ({l, co, ov, ci} !== 7'b1000_100) begin
            err_cnt++; $display("FAIL add_flags: last=%b cout=%b ovf=%b cin0=%b want 1000 1 0 0", l, co, ov, ci);
        end
        cmp_cnt++;
        if (ok !== 1'b1) begin err_cnt++; $display("FAIL add_proto: got %b want 1", ok); end
    endtask

    task automatic test_sub_borrow();
        logic [3:0][31:0] s; logic [3:0] l; logic co, ov, ci, ok;
        run_op(1'b1, {4{32'h0}}, {32'h0, 32'h0, 32'h0, 32'h1}, s, l, co, ov, ci, ok);
        cmp_cnt++;
        if (s !== {4{32'hFFFF_FFFF}}) begin err_cnt++; $display("FAIL sub_sums: got %h want all F", s); end
        cmp_cnt++;
        if ({l, co, ov, ci, ok} !== 8'b1000_0011) begin
            err_cnt++; $display("FAIL sub_flags: last=%b cout=%b ovf=%b cin0=%b ok=%b want 1000 0 0 1 1", l, co, ov, ci, ok);
        end
    endtask

    task automatic test_signed_ovf();
        logic [3:0][31:0] s; logic [3:0] l; logic co, ov, ci, ok;
        run_op(1'b0, {32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0}, {32'h1, 32'h0, 32'h0, 32'h0}, s, l, co, ov, ci, ok);
        cmp_cnt++;
        if (s !== {32'h8000_0000, 32'h0, 32'h0, 32'h0}) begin err_cnt++; $display("FAIL ovf_sums: got %h", s); end
        cmp_cnt++;
        if ({co, ov, ok} !== 3'b011) begin
            err_cnt++; $display("FAIL ovf_flags: cout=%b ovf=%b ok=%b want 0 1 1", co, ov, ok);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a_w, b_w;
        a_w = 32'hFFFF_FFFF;
        cmd_valid = 1'b1; cmd_sub = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_a = a_w; in_b = 32'h1;
        @(negedge clk);
        out_ready = 1'b0;
        in_b = 32'h0;
        for (int k = 0; k < 3; k++) begin
            #1;
            cmp_cnt++;
            if ({out_valid, in_ready, out_last, adder_cin} !== 4'b1001 || out_sum !== 32'h0) begin
                err_cnt++;
                $display("FAIL stall_%0d: valid/rdy/last/cin=%b sum=%h want 1001 0", k,
                         {out_valid, in_ready, out_last, adder_cin}, out_sum);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            b_w = 32'h0;
            in_b = b_w;
            @(negedge clk);
            cmp_cnt++;
            if (out_sum !== 32'h0 || out_last !== (i == 3)) begin
                err_cnt++; $display("FAIL resume_w%0d: sum=%h last=%b want 0 %b", i, out_sum, out_last, i == 3);
            end
        end
        in_valid = 1'b0;
        cmp_cnt++;
        if ({out_cout, out_ovf} !== 2'b10) begin
            err_cnt++; $display("FAIL resume_flags: cout=%b ovf=%b want 1 0", out_cout, out_ovf);
        end
        @(negedge clk);
        cmp_cnt++;
        if ({cmd_ready, out_valid} !== 2'b10) begin
            err_cnt++; $display("FAIL resume_idle: rdy/valid=%b want 10", {cmd_ready, out_valid});
        end
    endtask

    task automatic test_abort();
        logic [3:0][31:0] s; logic [3:0] l; logic co, ov, ci, ok;
        cmd_valid = 1'b1; cmd_sub = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h1;
        @(negedge clk);
        in_b = 32'h0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        cmp_cnt++;
        if ({cmd_ready, out_valid, out_last, in_ready} !== 4'b1000) begin
            err_cnt++; $display("FAIL abort_state: rdy/valid/last/inrdy=%b want 1000",
                                {cmd_ready, out_valid, out_last, in_ready});
        end
        run_op(1'b1, {4{32'h0}}, {32'h0, 32'h0, 32'h0, 32'h1}, s, l, co, ov, ci, ok);
        cmp_cnt++;
        if (s !== {4{32'hFFFF_FFFF}} || {l, co, ci, ok} !== 7'b1000_011) begin
            err_cnt++; $display("FAIL abort_then_sub: sums=%h last=%b cout=%b cin0=%b ok=%b", s, l, co, ci, ok);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0][31:0] s; logic [3:0] l; logic co, ov, ci, ok;
        cmd_valid = 1'b1; cmd_sub = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h1111_1111;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if ({cmd_ready, in_ready, out_valid, out_last} !== 4'b1000 || out_sum !== 32'h0) begin
            err_cnt++; $display("FAIL rst_mid: rdy/inrdy/valid/last=%b sum=%h want 1000 0",
                                {cmd_ready, in_ready, out_valid, out_last}, out_sum);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, {32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0}, {32'h1, 32'h0, 32'h0, 32'h0}, s, l, co, ov, ci, ok);
        cmp_cnt++;
        if (s !== {32'h8000_0000, 32'h0, 32'h0, 32'h0} || {l, co, ov, ok} !== 7'b1000_011) begin
            err_cnt++; $display("FAIL rst_then_op: sums=%h last=%b cout=%b ovf=%b ok=%b", s, l, co, ov, ok);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_sub = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_add_carry();
        test_sub_borrow();
        test_signed_ovf();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1);
    end

endmodule
